// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the serial instruction-memory loader.
package inst_mem_loader_pkg;

  // Loader frame-parser states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Instruction word width.
  localparam int unsigned INSTR_W = 32;

  // Word index position inside the byte address.
  localparam int unsigned WADDR_MSB = 10;
  localparam int unsigned WADDR_LSB = 2;
  localparam int unsigned WIDX_W    = WADDR_MSB - WADDR_LSB + 1;

  // Word index -> word-aligned byte address, zero-extended.
  function automatic logic [INSTR_W-1:0] word_to_addr(input logic [WIDX_W-1:0] idx);
    logic [INSTR_W-1:0] addr;
    addr = '0;
    addr[WADDR_MSB:WADDR_LSB] = idx;
    return addr;
  endfunction

  // CPU is held in reset only while a frame is being parsed.
  function automatic logic hold_active(input state_t s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
  endfunction

endpackage

// File: rtl/inst_mem_loader_timeout_ctr.sv
// Restartable idle counter: counts cycles while running, saturates at LIMIT.
module loader_timeout_ctr #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  // Idle cycle counter; restarts on clear or whenever not running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT_C) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == LIMIT_C);

endmodule

// File: rtl/inst_mem_loader.sv
// Serial frame loader: parses SYNC/count/data/checksum frames from a byte
// stream and emits 32-bit instruction memory writes while holding the CPU.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE       = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               RxValid,
  input  logic [7:0]         RxData,
  output logic               WriteEn,
  output logic [INSTR_W-1:0] WriteAddr,
  output logic [INSTR_W-1:0] WriteData,
  output logic               CpuHold,
  output logic               Done,
  output logic               Error,
  output logic [15:0]        WordCount
);

  state_t             r_state,    w_state_nxt;
  logic [7:0]         r_cnt_hi,   w_cnt_hi_nxt;
  logic [15:0]        r_count,    w_count_nxt;
  logic [1:0]         r_byte_idx, w_byte_idx_nxt;
  logic [INSTR_W-1:0] r_asm,      w_asm_nxt;
  logic [7:0]         r_csum,     w_csum_nxt;
  logic [15:0]        r_word_cnt, w_word_cnt_nxt;
  logic               r_we,       w_we_nxt;
  logic [INSTR_W-1:0] r_waddr,    w_waddr_nxt;
  logic [INSTR_W-1:0] r_wdata,    w_wdata_nxt;
  logic               r_done,     w_done_nxt;
  logic               r_error,    w_error_nxt;

  logic               w_run;
  logic               w_timeout;
  logic [15:0]        w_count_rx;
  logic [15:0]        w_wc_inc;
  logic [INSTR_W-1:0] w_asm_word;

  assign w_run      = hold_active(r_state);
  assign w_count_rx = {r_cnt_hi, RxData};
  assign w_wc_inc   = r_word_cnt + 16'd1;
  assign w_asm_word = {r_asm[INSTR_W-9:0], RxData};

  loader_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (w_run),
    .i_clear   (RxValid),
    .o_expired (w_timeout)
  );

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_hi_nxt   = r_cnt_hi;
    w_count_nxt    = r_count;
    w_byte_idx_nxt = r_byte_idx;
    w_asm_nxt      = r_asm;
    w_csum_nxt     = r_csum;
    w_word_cnt_nxt = r_word_cnt;
    w_we_nxt       = 1'b0;
    w_waddr_nxt    = r_waddr;
    w_wdata_nxt    = r_wdata;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;

    if (w_timeout && !RxValid) begin
      w_state_nxt = ST_ERR;
      w_error_nxt = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (RxValid && (RxData == SYNC_BYTE)) begin
            w_state_nxt    = ST_CNT_HI;
            w_done_nxt     = 1'b0;
            w_error_nxt    = 1'b0;
            w_word_cnt_nxt = '0;
            w_byte_idx_nxt = '0;
            w_csum_nxt     = '0;
            w_asm_nxt      = '0;
          end
        end
        ST_CNT_HI: begin
          if (RxValid) begin
            w_cnt_hi_nxt = RxData;
            w_state_nxt  = ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (RxValid) begin
            w_count_nxt = w_count_rx;
            if ((w_count_rx == 16'd0) || (32'(w_count_rx) > MEM_SIZE)) begin
              w_state_nxt = ST_ERR;
              w_error_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (RxValid) begin
            w_asm_nxt      = w_asm_word;
            w_csum_nxt     = r_csum ^ RxData;
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Strobe is registered, so it appears the cycle after the 4th byte
              // together with the already-incremented WordCount.
              w_we_nxt       = 1'b1;
              w_waddr_nxt    = word_to_addr(r_word_cnt[WIDX_W-1:0]);
              w_wdata_nxt    = w_asm_word;
              w_word_cnt_nxt = w_wc_inc;
              if (w_wc_inc == r_count) begin
                w_state_nxt = ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (RxValid) begin
            if (RxData == r_csum) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_ERR;
              w_error_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; async reset aborts any frame silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt_hi   <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_csum     <= '0;
      r_word_cnt <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt_hi   <= w_cnt_hi_nxt;
      r_count    <= w_count_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_asm      <= w_asm_nxt;
      r_csum     <= w_csum_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_we       <= w_we_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign WriteEn   = r_we;
  assign WriteAddr = r_waddr;
  assign WriteData = r_wdata;
  assign CpuHold   = w_run;
  assign Done      = r_done;
  assign Error     = r_error;
  assign WordCount = r_word_cnt;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with immediate-assertion checks.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RxValid;
  logic [7:0]  RxData;
  logic        WriteEn;
  logic [31:0] WriteAddr;
  logic [31:0] WriteData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [15:0] WordCount;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clk = ~clk;

  inst_mem_loader #(
    .MEM_SIZE       (512),
    .TIMEOUT_CYCLES (100),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .RxValid   (RxValid),
    .RxData    (RxData),
    .WriteEn   (WriteEn),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .CpuHold   (CpuHold),
    .Done      (Done),
    .Error     (Error),
    .WordCount (WordCount)
  );

  // Log every write strobe seen on the falling edge.
  always @(negedge clk) begin
    if (WriteEn === 1'b1) begin
      wr_addr_q.push_back(WriteAddr);
      wr_data_q.push_back(WriteData);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_addr(input int i);
    if (i < wr_addr_q.size()) return wr_addr_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] log_data(input int i);
    if (i < wr_data_q.size()) return wr_data_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    RxValid = 1'b1;
    RxData  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RxValid = 1'b0;
      RxData  = 8'h00;
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    RxValid = 1'b0;
    RxData  = 8'h00;
    idle(2);

    // Reset state
    check("rst_we",    32'(WriteEn),   32'd0);
    check("rst_addr",  WriteAddr,      32'd0);
    check("rst_data",  WriteData,      32'd0);
    check("rst_hold",  32'(CpuHold),   32'd0);
    check("rst_done",  32'(Done),      32'd0);
    check("rst_err",   32'(Error),     32'd0);
    check("rst_wc",    32'(WordCount), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    // Non-sync byte in IDLE is ignored
    send(8'h11);
    idle(1);
    check("idle_ignore_hold", 32'(CpuHold), 32'd0);

    // Two-word load, back-to-back bytes
    clear_log();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h20);
    send(8'h04);
    check("a_hold_mid", 32'(CpuHold), 32'd1);
    send(8'h00); send(8'h05);
    send(8'h20); send(8'h08); send(8'h00); send(8'h80);
    send(8'h89);
    idle(1);
    check("a_nwr",   32'(wr_addr_q.size()), 32'd2);
    check("a_addr0", log_addr(0), 32'h0000_0000);
    check("a_data0", log_data(0), 32'h2004_0005);
    check("a_addr1", log_addr(1), 32'h0000_0004);
    check("a_data1", log_data(1), 32'h2008_0080);
    check("a_done",  32'(Done),      32'd1);
    check("a_err",   32'(Error),     32'd0);
    check("a_wc",    32'(WordCount), 32'd2);
    check("a_hold",  32'(CpuHold),   32'd0);

    // Bad checksum
    clear_log();
    send(8'hA5);
    send(8'h00);
    check("b_done_clr", 32'(Done),    32'd0);
    check("b_hold",     32'(CpuHold), 32'd1);
    send(8'h02);
    send(8'h20); send(8'h04); send(8'h00); send(8'h05);
    send(8'h20); send(8'h08); send(8'h00); send(8'h80);
    send(8'h88);
    idle(1);
    check("b_err",  32'(Error),     32'd1);
    check("b_done", 32'(Done),      32'd0);
    check("b_nwr",  32'(wr_addr_q.size()), 32'd2);
    check("b_wc",   32'(WordCount), 32'd2);

    // Count above MEM_SIZE
    clear_log();
    send(8'hA5); send(8'h02); send(8'h01);
    idle(1);
    check("c_err",  32'(Error),     32'd1);
    check("c_hold", 32'(CpuHold),   32'd0);
    check("c_wc",   32'(WordCount), 32'd0);
    check("c_nwr",  32'(wr_addr_q.size()), 32'd0);

    // Count zero
    send(8'hA5); send(8'h00); send(8'h00);
    idle(1);
    check("c0_err", 32'(Error), 32'd1);

    // Count exactly MEM_SIZE is accepted; then left to time out
    send(8'hA5); send(8'h02); send(8'h00);
    idle(1);
    check("cmax_err",  32'(Error),   32'd0);
    check("cmax_hold", 32'(CpuHold), 32'd1);
    idle(120);
    check("cmax_to_err", 32'(Error), 32'd1);
    check("cmax_nwr",    32'(wr_addr_q.size()), 32'd0);

    // Timeout 3 bytes into word 1
    clear_log();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h20); send(8'h04); send(8'h00); send(8'h05);
    send(8'h11); send(8'h22); send(8'h33);
    idle(90);
    check("d_err_early",  32'(Error),   32'd0);
    check("d_hold_early", 32'(CpuHold), 32'd1);
    idle(20);
    check("d_err",   32'(Error),     32'd1);
    check("d_hold",  32'(CpuHold),   32'd0);
    check("d_wc",    32'(WordCount), 32'd1);
    check("d_nwr",   32'(wr_addr_q.size()), 32'd1);
    check("d_data0", log_data(0), 32'h2004_0005);

    // Asynchronous reset mid-DATA
    clear_log();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55);
    check("e_we_before", 32'(WriteEn), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("e_we",   32'(WriteEn),   32'd0);
    check("e_addr", WriteAddr,      32'd0);
    check("e_data", WriteData,      32'd0);
    check("e_hold", 32'(CpuHold),   32'd0);
    check("e_wc",   32'(WordCount), 32'd0);
    @(negedge clk);
    RxValid = 1'b0;
    reset_n = 1'b1;
    clear_log();
    idle(1);
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h22);
    idle(1);
    check("e2_nwr",  32'(wr_addr_q.size()), 32'd1);
    check("e2_addr", log_addr(0), 32'h0000_0000);
    check("e2_data", log_data(0), 32'hDEAD_BEEF);
    check("e2_done", 32'(Done),      32'd1);
    check("e2_wc",   32'(WordCount), 32'd1);

    // Sync byte value inside data
    clear_log();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
    send(8'hA5);
    idle(1);
    check("f_nwr",  32'(wr_addr_q.size()), 32'd1);
    check("f_data", log_data(0), 32'hA501_0203);
    check("f_done", 32'(Done),  32'd1);
    check("f_err",  32'(Error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles allowed between bytes inside a frame.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5: the frame start marker.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-006 SHALL have port RxValid, input, 1: RxData holds a received byte this cycle; at most one byte per cycle.
REQ-007 SHALL have port RxData, input, 8: the received byte.
REQ-008 SHALL have port WriteEn, output, 1: one-cycle instruction memory write strobe.
REQ-009 SHALL have port WriteAddr, output, 32: word-aligned byte address, with the word index in [10:2].
REQ-010 SHALL have port WriteData, output, 32: the instruction word to write.
REQ-011 SHALL have port CpuHold, output, 1: holds the CPU in reset while a frame is in progress.
REQ-012 SHALL have port Done, output, 1: the last frame loaded successfully.
REQ-013 SHALL have port Error, output, 1: the last frame was aborted.
REQ-014 SHALL have port WordCount, output, 16: the number of words written in the current or last frame.

Function
REQ-015 The frame format SHALL be: SYNC_BYTE, count high byte, count low byte, 4*count data bytes, then one checksum byte.
  - Data words arrive MSB first.
  - The checksum is the XOR of all data bytes.
REQ-016 The FSM states SHALL be IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE and ERR.
REQ-017 In IDLE, DONE or ERR, a SYNC_BYTE SHALL move the FSM to CNT_HI and:
  - clear Done and Error;
  - clear WordCount, the byte counter and the checksum accumulator.
  Other bytes in these states are ignored.
REQ-018 CNT_HI SHALL latch the high count byte and move to CNT_LO.
REQ-019 CNT_LO SHALL validate the count:
  - 0 or greater than MEM_SIZE -> ERR;
  - otherwise -> DATA.
REQ-020 DATA SHALL shift each byte into a 32-bit assembly register (left shift, new byte into [7:0]) and XOR it into the checksum.
REQ-021 On acceptance of every 4th data byte, the next cycle SHALL drive:
  - WriteEn = 1 for exactly one cycle;
  - WriteAddr = {WordCount, 2'b00}, zero-extended;
  - WriteData = the assembled word.
  WordCount increments in that same cycle.
REQ-022 Back-to-back bytes on consecutive cycles SHALL be accepted without loss.
  - A write strobe and a byte acceptance in the same cycle are legal.
REQ-023 When WordCount reaches the count, the FSM SHALL move to CHECK.
REQ-024 In CHECK, a byte equal to the checksum SHALL move the FSM to DONE with Done = 1; any other byte SHALL move it to ERR with Error = 1.
REQ-025 The idle counter SHALL reset on every accepted byte and run in CNT_HI, CNT_LO, DATA and CHECK.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - No write is issued for a partially assembled word.
REQ-026 CpuHold SHALL be 1 in every state except IDLE, DONE and ERR.
  - It falls in the cycle after DONE or ERR is entered.
REQ-027 SYNC_BYTE received inside a frame SHALL be treated as data, not as a restart.
REQ-028 WriteEn SHALL never assert outside DATA or the cycle immediately following DATA.

Reset
REQ-029 Assertion of reset_n low SHALL asynchronously force the following, mid-frame included, with no write strobe emitted:
  - state IDLE;
  - WriteEn = 0, WriteAddr = 0, WriteData = 0;
  - CpuHold = 0, Done = 0, Error = 0, WordCount = 0;
  - all counters and the checksum to 0.
REQ-030 After reset release, the block SHALL wait for SYNC_BYTE.

Structure
REQ-031 A shared package SHALL hold:
  - the FSM state encoding;
  - the SYNC_BYTE default;
  - the instruction word width (32);
  - the word-address slice constants ([10:2]).
REQ-032 One sub-module, loader_timeout_ctr, SHALL implement the restartable idle counter with a clear input and an expired output.
REQ-033 The instruction memory write port SHALL be connected outside this block.

Verification
REQ-034 Two-word load: bytes A5 00 02 20 04 00 05 20 08 00 80 89 on consecutive cycles SHALL produce:
  - a write of 20040005 at address 0x0;
  - a write of 20080080 at address 0x4;
  - Done = 1, Error = 0, WordCount = 2, and CpuHold falling.
REQ-035 Bad checksum: the same frame ending in 88 SHALL give Error = 1, Done = 0, with both writes already issued.
REQ-036 Count 0x0201 with MEM_SIZE = 512 SHALL give ERR right after CNT_LO, with no WriteEn.
REQ-037 A frame stalled 3 bytes into word 1 with TIMEOUT_CYCLES = 100 SHALL give Error after 100 idle cycles, with only word 0 written.
REQ-038 reset_n pulsed low mid-DATA SHALL:
  - drop all outputs to 0 asynchronously;
  - leave a subsequent valid frame loading correctly from address 0.
REQ-039 A data byte of A5 inside a frame SHALL be stored as data, and the frame SHALL complete normally.
